// File: rtl/conv_pkg.sv
// Shared constants and pixel/window types for the 3x3 convolution path.
package conv_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 5;
    localparam int unsigned IMG_H = 5;
    localparam int unsigned KER_N = 3;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned WIN_N = KER_N * KER_N;

    typedef logic [PIX_W-1:0] pix_t;

    // Element k sits at bits [k*PIX_W +: PIX_W], matching kernel row-major order.
    typedef pix_t [WIN_N-1:0] win_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: the output is the pixel pushed DEPTH enables ago.
module conv_line_buffer #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are left unreset: a new frame never reads them before overwriting.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator (raster pixels in, one neighbourhood per valid position out).
// Optional frame counter output enabled by defining CONV_WIN_FRAME_CNT_EN.
module conv_window_gen #(
    parameter int unsigned PIX_W = conv_pkg::PIX_W,
    parameter int unsigned IMG_W = conv_pkg::IMG_W,
    parameter int unsigned IMG_H = conv_pkg::IMG_H
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [PIX_W-1:0]                        in_pixel,
    output logic                                    win_valid,
    input  logic                                    win_ready,
    output logic [conv_pkg::WIN_N*PIX_W-1:0]        win_data,
    output logic [$clog2(IMG_H)-1:0]                win_row,
    output logic [$clog2(IMG_W)-1:0]                win_col,
    output logic                                    win_last
`ifdef CONV_WIN_FRAME_CNT_EN
    ,
    output logic [conv_pkg::OUT_W-1:0]              frame_cnt
`endif
);

    import conv_pkg::*;

    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_EDGE  = ROW_W'(KER_N - 1);
    localparam logic [COL_W-1:0] COL_EDGE  = COL_W'(KER_N - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             accept;
    logic             produce;

    logic [PIX_W-1:0] lb0_out;
    logic [PIX_W-1:0] lb1_out;
    logic [PIX_W-1:0] win_q [WIN_N];
    logic [PIX_W-1:0] win_d [WIN_N];

    logic                     valid_q, valid_d;
    logic [WIN_N*PIX_W-1:0]   data_q,  data_d;
    logic [ROW_W-1:0]         wrow_q,  wrow_d;
    logic [COL_W-1:0]         wcol_q,  wcol_d;
    logic                     last_q,  last_d;

    assign in_ready = !valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign produce  = accept && (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);

    // lb0 delays the stream by one row, lb1 by two rows.
    conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk  (clk),
        .en_i (accept),
        .d_i  (in_pixel),
        .q_o  (lb0_out)
    );

    conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk  (clk),
        .en_i (accept),
        .d_i  (lb0_out),
        .q_o  (lb1_out)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned r = 0; r < KER_N; r++) begin
                for (int unsigned c = 0; c < KER_N - 1; c++) begin
                    win_d[r*KER_N + c] = win_q[r*KER_N + c + 1];
                end
            end
            win_d[KER_N-1]   = lb1_out;
            win_d[2*KER_N-1] = lb0_out;
            win_d[WIN_N-1]   = in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    // The output register loads the post-shift window so it appears on the accepting edge.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        last_d  = last_q;
        if (valid_q && win_ready) begin
            valid_d = 1'b0;
        end
        if (produce) begin
            valid_d = 1'b1;
            for (int unsigned k = 0; k < WIN_N; k++) begin
                data_d[k*PIX_W +: PIX_W] = win_d[k];
            end
            wrow_d = row_q - ROW_EDGE;
            wcol_d = col_q - COL_EDGE;
            last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            last_q  <= last_d;
        end
    end

    assign win_valid = valid_q;
    assign win_data  = data_q;
    assign win_row   = wrow_q;
    assign win_col   = wcol_q;
    assign win_last  = last_q;

`ifdef CONV_WIN_FRAME_CNT_EN
    logic [OUT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (valid_q && win_ready && last_q) begin
            frame_cnt_d = frame_cnt_q + OUT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen against a frame-level window model.
module tb_conv_window_gen;

    localparam int W = 5;
    localparam int H = 5;
    localparam int P = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [P-1:0]      in_pixel;
    logic              win_valid;
    logic              win_ready;
    logic [9*P-1:0]    win_data;
    logic [2:0]        win_row;
    logic [2:0]        win_col;
    logic              win_last;
`ifdef CONV_WIN_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    conv_window_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_last  (win_last)
`ifdef CONV_WIN_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*P-1:0] d;
        int             r;
        int             c;
        bit             last;
    } win_s;

    win_s         exp_q[$];
    logic [P-1:0] pix_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int idx;          // raster position of the next pixel within the frame
    bit ev;           // expected win_valid this cycle
    int nwin;
    int nlast;
    int exp_fc;
    int spec_n;       // window number to compare against spec_val (0 = none)
    logic [9*P-1:0] spec_val;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pushes one frame of pixels and its (H-2)*(W-2) expected windows.
    task automatic add_frame(input int base, input bit rnd);
        logic [P-1:0] img [H][W];
        win_s w;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[r][c] = rnd ? P'($urandom) : P'(base + r*W + c + 1);
                pix_q.push_back(img[r][c]);
            end
        for (int r = 0; r <= H-3; r++)
            for (int c = 0; c <= W-3; c++) begin
                for (int k = 0; k < 9; k++) w.d[k*P +: P] = img[r + k/3][c + k%3];
                w.r = r;
                w.c = c;
                w.last = (r == H-3) && (c == W-3);
                exp_q.push_back(w);
            end
    endtask

    function automatic logic [9*P-1:0] pack9(input int base);
        logic [9*P-1:0] v;
        int tl[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        for (int k = 0; k < 9; k++) v[k*P +: P] = P'(tl[k] + base);
        return v;
    endfunction

    // rmode: 0 = always ready, 1 = random ready, 2 = 5-cycle stall after first window
    task automatic run(input int vprob, input int rmode);
        int cyc = 0;
        int stall_left = 0;
        bit stall_done = 0;
        bit held = 0;
        logic [9*P-1:0] held_d;
        logic [2:0] held_r, held_c;
        bit prod;
        win_s e;
        nwin = 0;
        nlast = 0;
        while ((pix_q.size() > 0 || exp_q.size() > 0 || ev) && cyc < 3000) begin
            @(negedge clk);
            in_valid = (pix_q.size() > 0) && ($urandom_range(99) < vprob);
            in_pixel = in_valid ? pix_q[0] : P'($urandom);
            case (rmode)
                0: win_ready = 1'b1;
                1: win_ready = 1'($urandom_range(1));
                default: win_ready = (stall_left == 0);
            endcase
            #1;
            check_eq("win_valid", win_valid, ev);
            check_eq("in_ready", in_ready, !ev || win_ready);
            if (held) begin
                check_eq("hold_data", win_data, held_d);
                check_eq("hold_row", win_row, held_r);
                check_eq("hold_col", win_col, held_c);
            end
`ifdef CONV_WIN_FRAME_CNT_EN
            check_eq("frame_cnt", frame_cnt, exp_fc);
`endif
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    nwin++;
                    check_eq("win_data", win_data, e.d);
                    check_eq("win_row", win_row, e.r);
                    check_eq("win_col", win_col, e.c);
                    check_eq("win_last", win_last, e.last);
                    if (spec_n == nwin) check_eq("spec_window", win_data, spec_val);
                    if (e.last) begin
                        nlast++;
                        exp_fc++;
                    end
                end
            end
            prod = 0;
            if (in_valid && in_ready) begin
                prod = (idx / W >= 2) && (idx % W >= 2);
                idx = (idx + 1) % (W*H);
                void'(pix_q.pop_front());
            end
            held   = win_valid && !win_ready;
            held_d = win_data;
            held_r = win_row;
            held_c = win_col;
            if (rmode == 2) begin
                if (stall_left > 0) stall_left--;
                else if (prod && !stall_done) begin
                    stall_left = 5;
                    stall_done = 1;
                end
            end
            ev = prod || (ev && !win_ready);
            cyc++;
        end
        if (cyc >= 3000) check_eq("timeout", cyc, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rst_win_valid", win_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_win_data", win_data, 0);
        check_eq("rst_win_row", win_row, 0);
        check_eq("rst_win_col", win_col, 0);
        check_eq("rst_win_last", win_last, 0);
`ifdef CONV_WIN_FRAME_CNT_EN
        check_eq("rst_frame_cnt", frame_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idx = 0;
        ev = 0;
        exp_fc = 0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        win_ready = 1'b1;
        spec_n = 0;
        spec_val = '0;
        do_reset();

        // Basic frame, first window checked against literal values
        add_frame(0, 0);
        spec_n = 1; spec_val = pack9(0);
        run(100, 0);
        check_eq("basic_count", nwin, 9);
        check_eq("basic_last", nlast, 1);

        // Backpressure after first window
        add_frame(0, 0);
        run(100, 2);
        check_eq("bp_count", nwin, 9);

        // Random input gaps
        add_frame(0, 0);
        run(50, 0);
        check_eq("gap_count", nwin, 9);
        spec_n = 0;

        // Reset mid-frame after 10 pixels, then a full frame
        for (int i = 0; i < 10; i++) pix_q.push_back(P'(i + 1));
        run(100, 0);
        check_eq("pre_rst_count", nwin, 0);
        do_reset();
        add_frame(0, 0);
        run(100, 0);
        check_eq("post_rst_count", nwin, 9);

        // Back-to-back frames: window 10 starts frame 2
        do_reset();
        add_frame(0, 0);
        add_frame(100, 0);
        spec_n = 10; spec_val = pack9(100);
        run(100, 0);
        spec_n = 0;
        check_eq("b2b_count", nwin, 18);
        check_eq("b2b_last", nlast, 2);
`ifdef CONV_WIN_FRAME_CNT_EN
        check_eq("b2b_frame_cnt", frame_cnt, 2);
`endif

        // Random pixels, random valid and ready, several frames
        for (int f = 0; f < 4; f++) add_frame(0, 1);
        run(60, 1);
        check_eq("rand_count", nwin, 36);
        check_eq("rand_last", nlast, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
